// File: rtl/div_pkg.sv
// div_pkg -- shared definitions for the restoring-divide controller.
//   div_state_e    : controller state encoding
//   DIV_ITERATIONS : default iteration count (= datapath dividend width)
//   DIV_CNT_W      : iteration counter width for the default count
//   div_cnt_w()    : counter width able to hold 0..n
package div_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    FIX,
    DONE
  } div_state_e;

  function automatic int unsigned div_cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  localparam int unsigned DIV_ITERATIONS = 32;
  localparam int unsigned DIV_CNT_W      = div_cnt_w(DIV_ITERATIONS);

endpackage

// File: rtl/div_iter_counter.sv
// div_iter_counter -- iteration counter for the divide controller.
//   clk     : clock
//   clr_i   : synchronous clear (wins over enable)
//   en_i    : count one iteration this cycle
//   count_o : iterations completed so far
//   tc_o    : this enabled cycle is the final iteration (count reaches ITERATIONS)
module div_iter_counter
  import div_pkg::*;
#(
  parameter int unsigned ITERATIONS = DIV_ITERATIONS,
  parameter int unsigned CW         = div_cnt_w(ITERATIONS)
) (
  input  logic          clk,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [CW-1:0] count_o,
  output logic          tc_o
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i)     count_d = '0;
    else if (en_i) count_d = count_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    count_q <= count_d;
  end

  assign count_o = count_q;
  // Flag the edge that brings the count to ITERATIONS so the FSM leaves RUN
  // on exactly that edge.
  assign tc_o    = en_i && (count_q == CW'(ITERATIONS - 1));

endmodule

// File: rtl/div_controller.sv
// div_controller -- sequencer for a restoring divider datapath.
//   clk          : clock, all state on posedge
//   Reset        : synchronous active-high reset (priority over Start)
//   Start        : request a division, sampled only in IDLE
//   Divisor_zero : divisor operand is zero, sampled in LOAD
//   Load         : one-cycle datapath load pulse
//   Run          : datapath iterate enable
//   pre_finish   : final remainder correction enable (FIX, DONE)
//   Ready        : quotient/remainder valid, held in IDLE until next Start
//   Busy         : LOAD, RUN or FIX
//   Div_by_zero  : last operation aborted on a zero divisor
//   Count        : iterations completed in the current operation
// Optional macro DIV_ZERO_DETECT_EN: abort straight to DONE on a zero
// divisor. Without it Divisor_zero is ignored and Div_by_zero reads 0.
module div_controller
  import div_pkg::*;
#(
  parameter  int unsigned ITERATIONS = DIV_ITERATIONS,
  localparam int unsigned CW         = div_cnt_w(ITERATIONS)
) (
  input  logic          clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic          Divisor_zero,
  output logic          Load,
  output logic          Run,
  output logic          pre_finish,
  output logic          Ready,
  output logic          Busy,
  output logic          Div_by_zero,
  output logic [CW-1:0] Count
);

  div_state_e state_q, state_d;
  logic       ready_q, ready_d;
  logic       dbz_q, dbz_d;
  logic       cnt_clr, cnt_en, cnt_tc;

  div_iter_counter #(
    .ITERATIONS (ITERATIONS),
    .CW         (CW)
  ) u_cnt (
    .clk     (clk),
    .clr_i   (cnt_clr),
    .en_i    (cnt_en),
    .count_o (Count),
    .tc_o    (cnt_tc)
  );

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ready_d    = ready_q;
    dbz_d      = dbz_q;
    cnt_clr    = Reset;
    cnt_en     = 1'b0;
    Load       = 1'b0;
    Run        = 1'b0;
    pre_finish = 1'b0;
    case (state_q)
      IDLE: begin
        // Clearing the count here makes Count read 0 already during LOAD.
        if (Start) begin
          state_d = LOAD;
          ready_d = 1'b0;
          dbz_d   = 1'b0;
          cnt_clr = 1'b1;
        end
      end
      LOAD: begin
        Load    = 1'b1;
        state_d = RUN;
`ifdef DIV_ZERO_DETECT_EN
        if (Divisor_zero) begin
          state_d = DONE;
          ready_d = 1'b1;
          dbz_d   = 1'b1;
        end
`endif
      end
      RUN: begin
        Run    = 1'b1;
        cnt_en = 1'b1;
        if (cnt_tc) state_d = FIX;
      end
      FIX: begin
        pre_finish = 1'b1;
        state_d    = DONE;
        ready_d    = 1'b1;
      end
      DONE: begin
        pre_finish = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign Ready = ready_q;
  assign Busy  = (state_q == LOAD) || (state_q == RUN) || (state_q == FIX);

`ifdef DIV_ZERO_DETECT_EN
  assign Div_by_zero = dbz_q;
`else
  assign Div_by_zero = 1'b0;
  logic unused_dz;
  assign unused_dz = Divisor_zero ^ dbz_q;
`endif

endmodule

// File: doc/div_controller.md
DIV_CONTROLLER -- requirements
Module: div_controller

Interface
REQ-001 SHALL have parameter ITERATIONS, default 32, number of restoring-divide iterations (equals datapath dividend width).
REQ-002 SHALL have port clk input 1: single clock, all state updates on posedge.
REQ-003 SHALL have port Reset input 1: synchronous, active-high reset.
REQ-004 SHALL have port Start input 1: request a new division, sampled only in IDLE.
REQ-005 SHALL have port Divisor_zero input 1: divisor operand equals zero, sampled in LOAD.
REQ-006 SHALL have port Load output 1: one-cycle pulse; top level ORs it into datapath Reset to load {0, dividend, 0}.
REQ-007 SHALL have port Run output 1: datapath iterate enable.
REQ-008 SHALL have port pre_finish output 1: iterations complete, enables datapath final remainder correction.
REQ-009 SHALL have port Ready output 1: quotient/remainder valid.
REQ-010 SHALL have port Busy output 1: high in LOAD, RUN, FIX.
REQ-011 SHALL have port Div_by_zero output 1: last operation aborted on zero divisor.
REQ-012 SHALL have port Count output clog2(ITERATIONS+1): iterations completed in current operation.

Function
REQ-013 SHALL implement states IDLE, LOAD, RUN, FIX, DONE.
REQ-014 SHALL move IDLE->LOAD on the edge where Start=1; Start in any other state is ignored.
REQ-015 SHALL hold LOAD exactly one cycle with Load=1, Count=0, Run=0, Ready=0.
REQ-016 SHALL move LOAD->RUN, assert Run=1, pre_finish=0, increment Count each RUN cycle.
REQ-017 SHALL move RUN->FIX on the edge where Count reaches ITERATIONS; RUN lasts exactly ITERATIONS cycles.
REQ-018 SHALL hold FIX one cycle with Run=0, pre_finish=1, Ready=0 (datapath right-shifts remainder half once).
REQ-019 SHALL hold DONE one cycle with pre_finish=1, Ready=1, then move to IDLE.
REQ-020 SHALL keep Ready=1 in IDLE after a completed operation until the next accepted Start or Reset; pre_finish=0 and Run=0 in IDLE so datapath holds.
REQ-021 SHALL produce Ready rising ITERATIONS+3 cycles after the Start-sampling edge (35 for default).
REQ-022 SHALL clear Div_by_zero on accepted Start; Count SHALL hold its final value in DONE/IDLE.
REQ-023 SHALL never assert Run and pre_finish together, nor Load with any other datapath control.
REQ-024 SHALL keep Start held high through DONE from restarting until the IDLE cycle (back-to-back ops allowed, one IDLE cycle minimum between).

Reset
REQ-025 SHALL on Reset=1 at any edge, including mid-operation, enter IDLE with Load=0, Run=0, pre_finish=0, Ready=0, Busy=0, Div_by_zero=0, Count=0.
REQ-026 SHALL give Reset priority over Start on the same edge.

Configuration
REQ-027 SHALL honour macro DIV_ZERO_DETECT_EN: when defined, Divisor_zero=1 in LOAD moves LOAD->DONE, sets Div_by_zero=1, skips RUN/FIX, Ready rises 2 cycles after Start-sampling edge, Count stays 0.
REQ-028 SHALL, without DIV_ZERO_DETECT_EN, ignore Divisor_zero, tie Div_by_zero=0, always run full sequence.

Structure
REQ-029 SHALL place state enum typedef, ITERATIONS default constant and counter-width constant in shared package div_pkg.
REQ-030 SHALL implement the iteration counter as sub-module div_iter_counter (clear, enable, terminal-count output).

Verification
REQ-031 SHALL cover: Reset then Start=1 one cycle -> Load pulse cycle 1, Run high cycles 2-33, pre_finish cycle 34-35, Ready=1 at cycle 35, Count=32.
REQ-032 SHALL cover: Start held high 40 cycles -> exactly one operation until IDLE, second Load at cycle 37, no Start-induced glitch mid-RUN.
REQ-033 SHALL cover: Reset asserted at RUN cycle 10 -> next cycle all outputs 0, state IDLE, Start next cycle restarts with Count=0.
REQ-034 SHALL cover: DIV_ZERO_DETECT_EN defined, Divisor_zero=1 -> Ready and Div_by_zero high 2 cycles after Start, Run never asserted; undefined -> full 35-cycle sequence, Div_by_zero=0.
REQ-035 SHALL cover: integration with datapath, dividend 100, divisor 7 -> quotient 14, remainder 2 when Ready=1; dividend 0xFFFFFFFF, divisor 1 -> quotient 0xFFFFFFFF, remainder 0.
